// File: rtl/lenet_pkg.sv
// Shared definitions for the LeNet memory/compute slice.
//   br_state_t     : burst-reader FSM state encoding
//   BR_DATA_WIDTH  : default DRAM word width
//   BR_ADDR_WIDTH  : default DRAM word-address width
`timescale 1ns/1ps
package lenet_pkg;

  localparam int BR_DATA_WIDTH = 32;
  localparam int BR_ADDR_WIDTH = 18;

  typedef enum logic [1:0] {
    BR_IDLE  = 2'd0,
    BR_ISSUE = 2'd1,
    BR_DRAIN = 2'd2,
    BR_DONE  = 2'd3
  } br_state_t;

endpackage

// File: rtl/dram_burst_reader_sync_fifo.sv
// sync_fifo: single-clock first-word-fall-through FIFO.
//   clk, rst : clock, asynchronous active-high reset (empties FIFO, zeroes storage)
//   push/din : write din when push (also accepted at full if a pop happens the same cycle)
//   pop      : drop the head entry (ignored when empty)
//   dout     : head entry, valid whenever count != 0
//   count    : number of stored entries, 0..DEPTH
`timescale 1ns/1ps
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_pop  = pop && (count != '0);
  assign do_push = push && ((count < CW'(DEPTH)) || do_pop);
  assign dout    = mem[rd_ptr];

  // Storage is reset so the head reads as zero after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
    end else if (do_push) begin
      mem[wr_ptr] <= din;
      wr_ptr      <= wr_ptr + PW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
    end else if (do_pop) begin
      rd_ptr <= rd_ptr + PW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else begin
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/dram_burst_reader.sv
// dram_burst_reader: issues `length` consecutive DRAM word reads from
// `base_addr`, absorbs variable read latency and delivers the words in order
// through a small FWFT FIFO.
//   clk, rst             : clock, asynchronous active-high reset
//   start/base_addr/length : burst request, sampled only in IDLE
//   dram_en_rd/dram_addr_rd : read request, one word per asserted cycle
//   dram_valid/dram_data_rd : in-order read return, latency >= 1
//   out_valid/out_data/out_ready : output stream
//   busy  : high outside IDLE
//   done  : one-cycle pulse after the last word is accepted
//   state : current FSM state (debug visibility)
//
// Handshake: a word transfers on every cycle where out_valid && out_ready are
// both high at the rising edge; out_valid never depends on out_ready, and
// out_data is stable while out_valid is high and out_ready is low.
`timescale 1ns/1ps
module dram_burst_reader
  import lenet_pkg::*;
#(
  parameter int DATA_WIDTH = BR_DATA_WIDTH,
  parameter int ADDR_WIDTH = BR_ADDR_WIDTH,
  parameter int LEN_WIDTH  = 12,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [LEN_WIDTH-1:0]  length,
  output logic                  dram_en_rd,
  output logic [ADDR_WIDTH-1:0] dram_addr_rd,
  input  logic                  dram_valid,
  input  logic [DATA_WIDTH-1:0] dram_data_rd,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  input  logic                  out_ready,
  output logic                  busy,
  output logic                  done,
  output br_state_t             state
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  br_state_t             state_q;
  br_state_t             state_d;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [LEN_WIDTH-1:0]  issue_left;
  logic [LEN_WIDTH-1:0]  deliver_left;
  logic [CW-1:0]         outstanding;
  logic [CW-1:0]         fifo_count;
  logic                  credit_ok;
  logic                  accept;
  logic                  push;
  logic                  pop;

  // Every word in flight or buffered holds a FIFO slot, so a return can
  // never find the FIFO full. The sum is computed one bit wider.
  assign credit_ok = ({1'b0, outstanding} + {1'b0, fifo_count}) < (CW+1)'(FIFO_DEPTH);
  assign accept    = start && (state_q == BR_IDLE);
  // Returns with nothing outstanding are strays (e.g. after a reset) and are dropped.
  assign push      = dram_valid && (outstanding != '0);
  assign out_valid = (fifo_count != '0);
  assign pop       = out_valid && out_ready;

  assign dram_addr_rd = addr_q;
  assign state        = state_q;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= BR_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic. DRAIN leaves on the final handshake itself so that
  // done lands exactly one cycle after it.
  always_comb begin
    state_d = state_q;
    case (state_q)
      BR_IDLE: begin
        if (start) state_d = (length == '0) ? BR_DONE : BR_ISSUE;
      end
      BR_ISSUE: begin
        if (dram_en_rd && (issue_left == LEN_WIDTH'(1))) state_d = BR_DRAIN;
      end
      BR_DRAIN: begin
        if ((deliver_left == '0) || (pop && (deliver_left == LEN_WIDTH'(1))))
          state_d = BR_DONE;
      end
      BR_DONE: state_d = BR_IDLE;
      default: state_d = BR_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    dram_en_rd = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    case (state_q)
      BR_IDLE:  ;
      BR_ISSUE: begin
        busy       = 1'b1;
        dram_en_rd = credit_ok;
      end
      BR_DRAIN: busy = 1'b1;
      BR_DONE: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: ;
    endcase
  end

  // Address and remaining-word counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q       <= '0;
      issue_left   <= '0;
      deliver_left <= '0;
    end else if (accept) begin
      addr_q       <= base_addr;
      issue_left   <= length;
      deliver_left <= length;
    end else begin
      if (dram_en_rd) begin
        addr_q     <= addr_q + ADDR_WIDTH'(1);
        issue_left <= issue_left - LEN_WIDTH'(1);
      end
      if (pop && (deliver_left != '0)) deliver_left <= deliver_left - LEN_WIDTH'(1);
    end
  end

  // Reads issued but not yet returned
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      outstanding <= '0;
    end else begin
      case ({dram_en_rd, push})
        2'b10:   outstanding <= outstanding + CW'(1);
        2'b01:   outstanding <= outstanding - CW'(1);
        default: outstanding <= outstanding;
      endcase
    end
  end

  sync_fifo #(
    .WIDTH (DATA_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   (dram_data_rd),
    .pop   (pop),
    .dout  (out_data),
    .count (fifo_count)
  );

endmodule

// File: tb/tb_dram_burst_reader.sv
// Directed testbench for dram_burst_reader with a fixed-latency DRAM model.
`timescale 1ns/1ps
module tb_dram_burst_reader;
  import lenet_pkg::*;

  localparam int DW   = 32;
  localparam int AW   = 18;
  localparam int LW   = 12;
  localparam int MAXL = 6;

  // ---------------- clock / reset / DUT ----------------
  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [AW-1:0] base_addr;
  logic [LW-1:0] length;
  logic          dram_en_rd;
  logic [AW-1:0] dram_addr_rd;
  logic          dram_valid;
  logic [DW-1:0] dram_data_rd;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic          out_ready;
  logic          busy;
  logic          done;
  br_state_t     state;

  always #5 clk = ~clk;

  dram_burst_reader dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .base_addr    (base_addr),
    .length       (length),
    .dram_en_rd   (dram_en_rd),
    .dram_addr_rd (dram_addr_rd),
    .dram_valid   (dram_valid),
    .dram_data_rd (dram_data_rd),
    .out_valid    (out_valid),
    .out_data     (out_data),
    .out_ready    (out_ready),
    .busy         (busy),
    .done         (done),
    .state        (state)
  );

  // ---------------- DRAM model ----------------
  function automatic logic [DW-1:0] dram_word(input logic [AW-1:0] a);
    return {a[13:0], a} ^ 32'hA5C3_0000;
  endfunction

  int            lat;
  logic          stray_valid;
  logic [MAXL-1:0] vld_pipe = '0;
  logic [AW-1:0] adr_pipe [MAXL];

  always @(posedge clk) begin
    vld_pipe <= {vld_pipe[MAXL-2:0], dram_en_rd};
    adr_pipe[0] <= dram_addr_rd;
    for (int i = 1; i < MAXL; i++) adr_pipe[i] <= adr_pipe[i-1];
  end

  assign dram_valid   = vld_pipe[lat-1] | stray_valid;
  assign dram_data_rd = stray_valid ? 32'hDEAD_BEEF : dram_word(adr_pipe[lat-1]);

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [DW-1:0] exp_q[$];
  logic [AW-1:0] iss_addr[$];
  int            iss_cyc[$];
  logic [DW-1:0] got_data[$];
  int            got_cyc[$];
  int done_cyc, done_cnt, busy_cnt;
  logic timed_out;

  // ---------------- driver tasks ----------------
  // Called just after a rising edge; the edge that samples start is cycle 0.
  task automatic do_start(input logic [AW-1:0] b, input logic [LW-1:0] l);
    start = 1'b1; base_addr = b; length = l;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Records requests, handshakes, busy and done per cycle until done is seen.
  // Leaves the bench one cycle after done (post-edge phase).
  task automatic observe(input int max_cyc, input int rdy_low, input int inj_at,
                         input logic [AW-1:0] inj_base, input logic [LW-1:0] inj_len);
    iss_addr.delete(); iss_cyc.delete(); got_data.delete(); got_cyc.delete();
    done_cyc = -1; done_cnt = 0; busy_cnt = 0; timed_out = 1'b1;
    for (int c = 1; c <= max_cyc; c++) begin
      @(negedge clk);
      if (dram_en_rd) begin iss_addr.push_back(dram_addr_rd); iss_cyc.push_back(c); end
      if (out_valid && out_ready) begin got_data.push_back(out_data); got_cyc.push_back(c); end
      if (busy) busy_cnt++;
      if (done) begin done_cnt++; if (done_cyc < 0) done_cyc = c; end
      @(posedge clk); #1;
      out_ready = (c + 1 > rdy_low);
      if (c + 1 == inj_at) begin start = 1'b1; base_addr = inj_base; length = inj_len; end
      else start = 1'b0;
      if (done_cyc >= 0) begin timed_out = 1'b0; break; end
    end
  endtask

  task automatic build_exp(input logic [AW-1:0] b, input int n);
    logic [AW-1:0] a;
    exp_q.delete();
    a = b;
    for (int i = 0; i < n; i++) begin
      exp_q.push_back(dram_word(a));
      a = a + AW'(1);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if ({dram_en_rd, dram_addr_rd, out_valid, out_data, busy, done} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: en=%b addr=%h ov=%b od=%h busy=%b done=%b, required all 0",
               dram_en_rd, dram_addr_rd, out_valid, out_data, busy, done);
    end
    n_checks++;
    if (state !== BR_IDLE) begin n_fail++; $display("FAIL reset_state: got %0d required %0d", state, BR_IDLE); end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({dram_en_rd, out_valid, busy, done} !== 4'b0) begin
      n_fail++;
      $display("FAIL post_reset_idle: en=%b ov=%b busy=%b done=%b, required 0", dram_en_rd, out_valid, busy, done);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_basic;
    lat = 2; out_ready = 1'b1;
    build_exp(18'h00100, 8);
    do_start(18'h00100, 12'd8);
    observe(200, 0, 0, '0, '0);
    n_checks++;
    if (timed_out !== 1'b0) begin n_fail++; $display("FAIL basic_timeout: done never seen"); end
    n_checks++;
    if (iss_addr.size() != 8) begin n_fail++; $display("FAIL basic_issue_count: got %0d required 8", iss_addr.size()); end
    for (int i = 0; i < iss_addr.size(); i++) begin
      n_checks++;
      if (iss_addr[i] !== AW'(18'h00100 + i) || iss_cyc[i] != 1 + i) begin
        n_fail++;
        $display("FAIL basic_issue[%0d]: got addr %h cycle %0d required addr %h cycle %0d",
                 i, iss_addr[i], iss_cyc[i], AW'(18'h00100 + i), 1 + i);
      end
    end
    n_checks++;
    if (got_data.size() != 8) begin n_fail++; $display("FAIL basic_word_count: got %0d required 8", got_data.size()); end
    for (int i = 0; i < got_data.size() && exp_q.size() > 0; i++) begin
      logic [DW-1:0] e;
      e = exp_q.pop_front();
      n_checks++;
      if (got_data[i] !== e) begin n_fail++; $display("FAIL basic_word[%0d]: got %h required %h", i, got_data[i], e); end
    end
    n_checks++;
    if (got_cyc.size() == 0 || got_cyc[0] != 4) begin
      n_fail++; $display("FAIL basic_first_out_cycle: got %0d required 4", (got_cyc.size() == 0) ? -1 : got_cyc[0]);
    end
    n_checks++;
    if (done_cyc != 12 || done_cnt != 1) begin n_fail++; $display("FAIL basic_done: got cycle %0d required 12", done_cyc); end
    n_checks++;
    if (busy_cnt != 12) begin n_fail++; $display("FAIL basic_busy_cycles: got %0d required 12", busy_cnt); end
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_fail++; $display("FAIL basic_after_done: busy=%b done=%b required 0 0", busy, done);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure;
    int early;
    lat = 3; out_ready = 1'b0;
    build_exp(18'h00200, 10);
    do_start(18'h00200, 12'd10);
    observe(300, 20, 0, '0, '0);
    early = 0;
    foreach (iss_cyc[i]) if (iss_cyc[i] <= 20) early++;
    n_checks++;
    if (timed_out !== 1'b0) begin n_fail++; $display("FAIL bp_timeout: done never seen"); end
    n_checks++;
    if (early != 4) begin n_fail++; $display("FAIL bp_stall_issues: got %0d reads while stalled required 4", early); end
    n_checks++;
    if (iss_addr.size() != 10) begin n_fail++; $display("FAIL bp_issue_count: got %0d required 10", iss_addr.size()); end
    n_checks++;
    if (got_data.size() != 10) begin n_fail++; $display("FAIL bp_word_count: got %0d required 10", got_data.size()); end
    for (int i = 0; i < got_data.size() && exp_q.size() > 0; i++) begin
      logic [DW-1:0] e;
      e = exp_q.pop_front();
      n_checks++;
      if (got_data[i] !== e) begin n_fail++; $display("FAIL bp_word[%0d]: got %h required %h", i, got_data[i], e); end
    end
    n_checks++;
    if (got_cyc.size() == 0 || got_cyc[0] != 21) begin
      n_fail++; $display("FAIL bp_first_out_cycle: got %0d required 21", (got_cyc.size() == 0) ? -1 : got_cyc[0]);
    end
    out_ready = 1'b1;
  endtask

  task automatic test_wrap;
    logic [AW-1:0] exp_a [4];
    exp_a[0] = 18'h3FFFE; exp_a[1] = 18'h3FFFF; exp_a[2] = 18'h00000; exp_a[3] = 18'h00001;
    lat = 1; out_ready = 1'b1;
    build_exp(18'h3FFFE, 4);
    do_start(18'h3FFFE, 12'd4);
    observe(100, 0, 0, '0, '0);
    n_checks++;
    if (iss_addr.size() != 4) begin n_fail++; $display("FAIL wrap_issue_count: got %0d required 4", iss_addr.size()); end
    for (int i = 0; i < iss_addr.size() && i < 4; i++) begin
      n_checks++;
      if (iss_addr[i] !== exp_a[i]) begin n_fail++; $display("FAIL wrap_addr[%0d]: got %h required %h", i, iss_addr[i], exp_a[i]); end
    end
    for (int i = 0; i < got_data.size() && exp_q.size() > 0; i++) begin
      logic [DW-1:0] e;
      e = exp_q.pop_front();
      n_checks++;
      if (got_data[i] !== e) begin n_fail++; $display("FAIL wrap_word[%0d]: got %h required %h", i, got_data[i], e); end
    end
    n_checks++;
    if (done_cyc != 7) begin n_fail++; $display("FAIL wrap_done_cycle: got %0d required 7", done_cyc); end
  endtask

  task automatic test_zero_length;
    lat = 2; out_ready = 1'b1;
    do_start(18'h00ABC, 12'd0);
    observe(20, 0, 0, '0, '0);
    n_checks++;
    if (iss_addr.size() != 0) begin n_fail++; $display("FAIL zero_issue_count: got %0d required 0", iss_addr.size()); end
    n_checks++;
    if (got_data.size() != 0) begin n_fail++; $display("FAIL zero_word_count: got %0d required 0", got_data.size()); end
    n_checks++;
    if (done_cyc != 1) begin n_fail++; $display("FAIL zero_done_cycle: got %0d required 1", done_cyc); end
    n_checks++;
    if (busy_cnt != 1) begin n_fail++; $display("FAIL zero_busy_cycles: got %0d required 1", busy_cnt); end
  endtask

  task automatic test_start_ignored;
    lat = 2; out_ready = 1'b1;
    build_exp(18'h00040, 6);
    do_start(18'h00040, 12'd6);
    observe(200, 0, 3, 18'h03000, 12'd2);
    n_checks++;
    if (iss_addr.size() != 6) begin n_fail++; $display("FAIL ign_issue_count: got %0d required 6", iss_addr.size()); end
    for (int i = 0; i < iss_addr.size(); i++) begin
      n_checks++;
      if (iss_addr[i] !== AW'(18'h00040 + i)) begin
        n_fail++; $display("FAIL ign_addr[%0d]: got %h required %h", i, iss_addr[i], AW'(18'h00040 + i));
      end
    end
    n_checks++;
    if (got_data.size() != 6) begin n_fail++; $display("FAIL ign_word_count: got %0d required 6", got_data.size()); end
    for (int i = 0; i < got_data.size() && exp_q.size() > 0; i++) begin
      logic [DW-1:0] e;
      e = exp_q.pop_front();
      n_checks++;
      if (got_data[i] !== e) begin n_fail++; $display("FAIL ign_word[%0d]: got %h required %h", i, got_data[i], e); end
    end
    n_checks++;
    if (done_cyc != 10) begin n_fail++; $display("FAIL ign_done_cycle: got %0d required 10", done_cyc); end
  endtask

  task automatic test_reset_mid_burst;
    int cnt;
    lat = 4; out_ready = 1'b1;
    do_start(18'h00500, 12'd8);
    cnt = 0;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      if (dram_en_rd) cnt++;
      @(posedge clk); #1;
    end
    n_checks++;
    if (cnt != 3) begin n_fail++; $display("FAIL rstmid_issued: got %0d required 3", cnt); end
    rst = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({dram_en_rd, dram_addr_rd, out_valid, out_data, busy, done} !== '0) begin
      n_fail++; $display("FAIL rstmid_in_reset: en=%b addr=%h ov=%b od=%h busy=%b done=%b, required all 0",
                         dram_en_rd, dram_addr_rd, out_valid, out_data, busy, done);
    end
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      if (k == 0) rst = 1'b0;
      stray_valid = (k >= 3 && k <= 5);
      @(negedge clk);
      n_checks++;
      if ({dram_en_rd, out_valid, out_data, busy, done} !== '0 || state !== BR_IDLE) begin
        n_fail++; $display("FAIL rstmid_stray[%0d]: en=%b ov=%b od=%h busy=%b done=%b state=%0d, required idle/0",
                           k, dram_en_rd, out_valid, out_data, busy, done, state);
      end
    end
    @(posedge clk); #1;
    stray_valid = 1'b0;
    lat = 2;
    build_exp(18'h00600, 2);
    do_start(18'h00600, 12'd2);
    observe(100, 0, 0, '0, '0);
    n_checks++;
    if (iss_addr.size() != 2 || iss_addr[0] !== 18'h00600 || iss_addr[1] !== 18'h00601) begin
      n_fail++; $display("FAIL rstmid_next_addrs: got %0d reads, required 2 at 00600/00601", iss_addr.size());
    end
    n_checks++;
    if (got_data.size() != 2) begin n_fail++; $display("FAIL rstmid_next_count: got %0d required 2", got_data.size()); end
    for (int i = 0; i < got_data.size() && exp_q.size() > 0; i++) begin
      logic [DW-1:0] e;
      e = exp_q.pop_front();
      n_checks++;
      if (got_data[i] !== e) begin n_fail++; $display("FAIL rstmid_next_word[%0d]: got %h required %h", i, got_data[i], e); end
    end
    n_checks++;
    if (done_cyc != 6) begin n_fail++; $display("FAIL rstmid_next_done: got %0d required 6", done_cyc); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    rst = 1'b1; start = 1'b0; base_addr = '0; length = '0;
    out_ready = 1'b1; stray_valid = 1'b0; lat = 2;
    test_reset();
    test_basic();
    test_backpressure();
    test_wrap();
    test_zero_length();
    test_start_ignored();
    test_reset_mid_burst();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
